// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and per-digit BCD limits for the countdown timer
package timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;
  function automatic logic [3:0] digit_limit(input int i);
    return (i % 2 == 0) ? 4'd9 : 4'd5;
  endfunction
endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one BCD digit register with load, carry-chained increment and borrow-chained decrement
module bcd_down_digit #(
  parameter logic [3:0] LIMIT = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] q,
  output logic       carry,
  output logic       borrow
);
  assign carry = inc && q == LIMIT;
  assign borrow = dec && q == 4'd0;
  always_ff @(posedge clk)
    if (rst || load) q <= load_val;
    else if (inc) q <= carry ? 4'd0 : q + 4'd1;
    else if (dec) q <= borrow ? LIMIT : q - 4'd1;
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: BCD mm:ss countdown with set/run/pause/alarm control, 1 s prescaler and alarm blink
module countdown_timer
  import timer_pkg::*;
#(
  parameter int CLK_FREQ_KHZ = 50000,
  parameter int NUM_DIGITS = 4,
  parameter logic [NUM_DIGITS*4-1:0] PRESET_BCD = 16'h0300,
  parameter int ALARM_SEC = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_stop_pls,
  input  logic                    set_pls,
  input  logic                    clear_pls,
  output logic [NUM_DIGITS*4-1:0] digits_bcd,
  output logic                    running,
  output logic                    timeup,
  output logic                    alarm_blink,
  output logic                    tick
);
  localparam int W = NUM_DIGITS * 4;
  localparam int TICKS = CLK_FREQ_KHZ * 1000;
  localparam int PW = $clog2(TICKS);
  localparam int AW = $clog2(ALARM_SEC + 1);
  localparam logic [PW-1:0] LIMIT = PW'(TICKS - 1);
  localparam logic [PW-1:0] HALF = PW'(TICKS / 2 - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC - 1);
  state_t state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [AW-1:0] acnt, acnt_nx;
  logic blink, blink_nx;
  logic load, inc_en, dec_en;
  logic [NUM_DIGITS:0] carry, borrow;
  logic unused_chain;
  wire wrap = presc == LIMIT;
  wire any_pls = clear_pls || start_stop_pls || set_pls;
  wire is_zero = digits_bcd == '0;
  wire is_last = digits_bcd == W'(1);
  always_comb begin
    state_nx = state;
    presc_nx = presc;
    acnt_nx = acnt;
    blink_nx = 1'b0;
    load = 1'b0;
    inc_en = 1'b0;
    dec_en = 1'b0;
    case (state)
      IDLE:
        if (clear_pls) load = 1'b1;
        else if (start_stop_pls) begin
          state_nx = is_zero ? IDLE : RUN;
          presc_nx = '0;
        end else if (set_pls) inc_en = 1'b1;
      RUN:
        if (clear_pls) begin
          state_nx = IDLE;
          load = 1'b1;
          presc_nx = '0;
        end else begin
          presc_nx = wrap ? '0 : presc + 1'b1;
          dec_en = wrap;
          // the final decrement wins over a same-cycle pause so a zero count never sits in PAUSE
          if (wrap && is_last) begin
            state_nx = ALARM;
            acnt_nx = '0;
            blink_nx = 1'b1;
          end else if (start_stop_pls) state_nx = PAUSE;
        end
      PAUSE:
        if (clear_pls) begin
          state_nx = IDLE;
          load = 1'b1;
          presc_nx = '0;
        end else if (start_stop_pls) state_nx = RUN;
      ALARM:
        if (any_pls || (wrap && acnt == ALARM_LAST)) begin
          state_nx = IDLE;
          load = 1'b1;
          presc_nx = '0;
        end else begin
          presc_nx = wrap ? '0 : presc + 1'b1;
          acnt_nx = wrap ? acnt + 1'b1 : acnt;
          blink_nx = (wrap || presc == HALF) ? ~blink : blink;
        end
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      presc <= '0;
      acnt <= '0;
      blink <= 1'b0;
    end else begin
      state <= state_nx;
      presc <= presc_nx;
      acnt <= acnt_nx;
      blink <= blink_nx;
    end
  assign carry[0] = 1'b0;
  assign borrow[0] = dec_en;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    logic inc;
    if (i == 2) begin : g_set
      assign inc = inc_en;
    end else if (i > 2) begin : g_chain
      assign inc = carry[i];
    end else begin : g_sec
      assign inc = 1'b0;
    end
    bcd_down_digit #(.LIMIT(digit_limit(i))) u_dig (
      .clk(clk),
      .rst(rst),
      .load(load),
      .load_val(PRESET_BCD[4*i+:4]),
      .inc(inc),
      .dec(borrow[i]),
      .q(digits_bcd[4*i+:4]),
      .carry(carry[i+1]),
      .borrow(borrow[i+1])
    );
  end
  assign unused_chain = ^{carry, borrow[NUM_DIGITS]};
  assign running = state == RUN;
  assign timeup = state == ALARM;
  assign alarm_blink = blink;
  assign tick = (state == RUN || state == ALARM) && wrap;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed vector table on two presets plus random pulses against a seconds-based model
module tb_countdown_timer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [2:0] pa, pb;
  logic [15:0] da, db;
  logic run_a, up_a, bl_a, tk_a, run_b, up_b, bl_b, tk_b;
  countdown_timer #(.CLK_FREQ_KHZ(1), .NUM_DIGITS(4), .PRESET_BCD(16'h0003), .ALARM_SEC(2)) dut_a (
    .clk(clk), .rst(rst), .start_stop_pls(pa[1]), .set_pls(pa[0]), .clear_pls(pa[2]),
    .digits_bcd(da), .running(run_a), .timeup(up_a), .alarm_blink(bl_a), .tick(tk_a));
  countdown_timer #(.CLK_FREQ_KHZ(1), .NUM_DIGITS(4), .PRESET_BCD(16'h0100), .ALARM_SEC(2)) dut_b (
    .clk(clk), .rst(rst), .start_stop_pls(pb[1]), .set_pls(pb[0]), .clear_pls(pb[2]),
    .digits_bcd(db), .running(run_b), .timeup(up_b), .alarm_blink(bl_b), .tick(tk_b));
  typedef struct packed {
    logic        b;
    logic [2:0]  p;
    logic [7:0]  n;
    logic [15:0] w;
    logic [15:0] d;
    logic [3:0]  f;
  } vec_t;
  localparam int NV = 30;
  vec_t tbl [NV];
  int applied = 0;
  int miscmp = 0;
  int secs, mode, phase, aticks;
  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    applied++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got digits/run/up/blink/tick %h_%b want %h_%b", name, act[19:4], act[3:0], exp[19:4], exp[3:0]);
    end
  endtask
  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction
  function automatic logic [19:0] model_out();
    return {to_bcd(secs), mode == 1, mode == 3, mode == 3 && phase < 500, (mode == 1 || mode == 3) && phase == 999};
  endfunction
  task automatic model_reload();
    mode = 0;
    secs = 3;
    phase = 0;
  endtask
  task automatic model_step(input logic r, input logic [2:0] p);
    logic w;
    w = phase == 999;
    if (r) begin
      model_reload();
      aticks = 0;
    end else
      case (mode)
        0: if (p[2]) secs = 3;
           else if (p[1]) begin
             if (secs != 0) begin mode = 1; phase = 0; end
           end else if (p[0]) secs = secs % 60 + ((secs / 60 + 1) % 60) * 60;
        1: if (p[2]) model_reload();
           else begin
             phase = (phase + 1) % 1000;
             if (w) secs--;
             if (w && secs == 0) begin mode = 3; phase = 0; aticks = 0; end
             else if (p[1]) mode = 2;
           end
        2: if (p[2]) model_reload();
           else if (p[1]) mode = 1;
        default:
          if (p != 3'b000 || (w && aticks == 1)) model_reload();
          else begin
            phase = (phase + 1) % 1000;
            if (w) aticks++;
          end
      endcase
  endtask
  initial begin
    tbl = '{
      {1'b0, 3'b010, 8'd1, 16'd0,    16'h0003, 4'b1000},
      {1'b0, 3'b000, 8'd0, 16'd999,  16'h0003, 4'b1001},
      {1'b0, 3'b000, 8'd0, 16'd1,    16'h0002, 4'b1000},
      {1'b0, 3'b000, 8'd0, 16'd1000, 16'h0001, 4'b1000},
      {1'b0, 3'b000, 8'd0, 16'd999,  16'h0001, 4'b1001},
      {1'b0, 3'b000, 8'd0, 16'd1,    16'h0000, 4'b0110},
      {1'b0, 3'b000, 8'd0, 16'd499,  16'h0000, 4'b0110},
      {1'b0, 3'b000, 8'd0, 16'd1,    16'h0000, 4'b0100},
      {1'b0, 3'b000, 8'd0, 16'd500,  16'h0000, 4'b0110},
      {1'b0, 3'b000, 8'd0, 16'd999,  16'h0000, 4'b0101},
      {1'b0, 3'b000, 8'd0, 16'd1,    16'h0003, 4'b0000},
      {1'b0, 3'b010, 8'd1, 16'd3000, 16'h0000, 4'b0110},
      {1'b0, 3'b001, 8'd1, 16'd0,    16'h0003, 4'b0000},
      {1'b0, 3'b010, 8'd1, 16'd1500, 16'h0002, 4'b1000},
      {1'b0, 3'b110, 8'd1, 16'd0,    16'h0003, 4'b0000},
      {1'b0, 3'b010, 8'd1, 16'd399,  16'h0003, 4'b1000},
      {1'b0, 3'b010, 8'd1, 16'd0,    16'h0003, 4'b0000},
      {1'b0, 3'b000, 8'd0, 16'd4999, 16'h0003, 4'b0000},
      {1'b0, 3'b010, 8'd1, 16'd0,    16'h0003, 4'b1000},
      {1'b0, 3'b000, 8'd0, 16'd599,  16'h0003, 4'b1001},
      {1'b0, 3'b000, 8'd0, 16'd1,    16'h0002, 4'b1000},
      {1'b0, 3'b100, 8'd1, 16'd0,    16'h0003, 4'b0000},
      {1'b1, 3'b010, 8'd1, 16'd1000, 16'h0059, 4'b1000},
      {1'b1, 3'b100, 8'd1, 16'd0,    16'h0100, 4'b0000},
      {1'b1, 3'b001, 8'd2, 16'd0,    16'h0300, 4'b0000},
      {1'b1, 3'b001, 8'd3, 16'd0,    16'h0600, 4'b0000},
      {1'b1, 3'b001, 8'd53, 16'd0,   16'h5900, 4'b0000},
      {1'b1, 3'b001, 8'd1, 16'd0,    16'h0000, 4'b0000},
      {1'b1, 3'b010, 8'd1, 16'd5,    16'h0000, 4'b0000},
      {1'b1, 3'b111, 8'd1, 16'd0,    16'h0100, 4'b0000}
    };
    rst = 1'b1;
    pa = '0;
    pb = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_a", {da, run_a, up_a, bl_a, tk_a}, {16'h0003, 4'b0000});
    check("reset_b", {db, run_b, up_b, bl_b, tk_b}, {16'h0100, 4'b0000});
    for (int i = 0; i < NV; i++) begin
      for (int k = 0; k < int'(tbl[i].n); k++) begin
        if (tbl[i].b) pb = tbl[i].p; else pa = tbl[i].p;
        @(negedge clk);
        pa = '0;
        pb = '0;
      end
      repeat (int'(tbl[i].w)) @(negedge clk);
      if (tbl[i].b) check($sformatf("vec%0d", i), {db, run_b, up_b, bl_b, tk_b}, {tbl[i].d, tbl[i].f});
      else check($sformatf("vec%0d", i), {da, run_a, up_a, bl_a, tk_a}, {tbl[i].d, tbl[i].f});
    end
    pa = 3'b010;
    @(negedge clk);
    pa = '0;
    repeat (1200) @(negedge clk);
    check("run_mid", {da, run_a, up_a, bl_a, tk_a}, {16'h0002, 4'b1000});
    rst = 1'b1;
    pa = 3'b010;
    @(negedge clk);
    rst = 1'b0;
    pa = '0;
    check("rst_override", {da, run_a, up_a, bl_a, tk_a}, {16'h0003, 4'b0000});
    model_reload();
    aticks = 0;
    for (int c = 0; c < 30000; c++) begin
      logic r;
      logic [2:0] p;
      int u;
      check("random", {da, run_a, up_a, bl_a, tk_a}, model_out());
      u = int'($urandom_range(0, 19999));
      r = u == 0;
      p = (u >= 1 && u <= 25) ? 3'b010 :
          (u >= 26 && u <= 31) ? 3'b100 :
          (u >= 32 && u <= 36) ? 3'b001 :
          (u == 37) ? 3'($urandom_range(1, 7)) : 3'b000;
      rst = r;
      pa = p;
      @(posedge clk);
      model_step(r, p);
      @(negedge clk);
      rst = 1'b0;
      pa = '0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscmp);
    $finish;
  end
endmodule
